// File: rtl/key_bank_pkg.sv
// Shared types and constants for the key bank: FSM state encoding,
// byte width and the bytes-per-key helper.
package key_bank_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    // Number of byte transfers needed to fill one key register.
    function automatic int bytes_per_key(input int key_w);
        return key_w / BYTE_W;
    endfunction

endpackage : key_bank_pkg

// File: rtl/key_slot.sv
// One key register of the bank. Written only on commit, wiped by the
// synchronous clear, zeroed by the asynchronous reset.
module key_slot
    import key_bank_pkg::*;
#(
    parameter int KEY_W = 64
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clr_i,
    input  logic             we_i,
    input  logic [KEY_W-1:0] d_i,
    output logic [KEY_W-1:0] q_o
);

    logic [KEY_W-1:0] key_q;
    logic [KEY_W-1:0] key_d;

    // Next value: clear wins over write, otherwise hold.
    always_comb begin
        key_d = key_q;
        if (clr_i) begin
            key_d = '0;
        end else if (we_i) begin
            key_d = d_i;
        end
    end

    // Key storage register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            key_q <= '0;
        end else begin
            key_q <= key_d;
        end
    end

    assign q_o = key_q;

endmodule : key_slot

// File: rtl/key_bank.sv
// Bank of NUM_KEYS key registers loaded byte-serially (MSB first) from the
// I2C byte stream. A load stages all bytes in a shift register and writes
// the target slot in a single COMMIT cycle, so a slot never shows a
// partially loaded key. key_valid marks slots holding a committed key.
//
// Byte handshake: a byte is transferred on a rising edge where
// byte_valid && byte_ready. byte_ready is high only in LOAD and is forced
// low while clear is high; byte_valid may drop for any number of cycles.
module key_bank
    import key_bank_pkg::*;
#(
    parameter  int NUM_KEYS = 3,
    parameter  int KEY_W    = 64,
    localparam int IDX_W    = $clog2(NUM_KEYS)
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                load_start,
    input  logic [IDX_W-1:0]    load_idx,
    input  logic [7:0]          byte_in,
    input  logic                byte_valid,
    output logic                byte_ready,
    input  logic                clear,
    input  logic [IDX_W-1:0]    rd_sel,
    output logic [KEY_W-1:0]    key_out,
    output logic [NUM_KEYS-1:0] key_valid,
    output logic                busy,
    output logic                load_done,
    output logic                err,
    output logic [1:0]          dbg_state
);

    localparam int                BPK        = bytes_per_key(KEY_W);
    localparam int                CNT_W      = $clog2(BPK) + 1;
    localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(BPK - 1);
    localparam logic [IDX_W:0]    NUM_KEYS_W = (IDX_W + 1)'(NUM_KEYS);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [KEY_W-1:0]      stage_q, stage_d;
    logic [NUM_KEYS-1:0]   valid_q, valid_d;
    logic                  err_q, err_d;
    logic                  commit;
    logic                  accept;

    logic [KEY_W-1:0]      slot_val [NUM_KEYS];

    // FSM next state, staging shift, byte counter, valid flags and error pulse.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        commit  = 1'b0;
        accept  = 1'b0;
        if (clear) begin
            // Wipe everything and abort any load in flight.
            state_d = ST_IDLE;
            cnt_d   = '0;
            stage_d = '0;
            valid_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (load_start) begin
                        if ({1'b0, load_idx} < NUM_KEYS_W) begin
                            idx_d            = load_idx;
                            valid_d[load_idx] = 1'b0;
                            cnt_d            = '0;
                            state_d          = ST_LOAD;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    // A new request while loading is rejected, the load carries on.
                    if (load_start) begin
                        err_d = 1'b1;
                    end
                    if (byte_valid) begin
                        accept  = 1'b1;
                        stage_d = {stage_q[KEY_W-BYTE_W-1:0], byte_in};
                        cnt_d   = cnt_q + 1'b1;
                        if (cnt_q == LAST_CNT) begin
                            state_d = ST_COMMIT;
                        end
                    end
                end
                ST_COMMIT: begin
                    commit         = 1'b1;
                    valid_d[idx_q] = 1'b1;
                    cnt_d          = '0;
                    state_d        = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Control and staging registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            stage_q <= '0;
            valid_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Key registers: only the committing slot is written.
    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_slot
        key_slot #(
            .KEY_W (KEY_W)
        ) u_slot (
            .clk   (clk),
            .n_rst (n_rst),
            .clr_i (clear),
            .we_i  (commit && (idx_q == IDX_W'(g))),
            .d_i   (stage_q),
            .q_o   (slot_val[g])
        );
    end

    // Read mux; an out-of-range select reads as zero.
    always_comb begin
        key_out = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (rd_sel == IDX_W'(i)) begin
                key_out = slot_val[i];
            end
        end
    end

    assign byte_ready = (state_q == ST_LOAD) && !clear;
    assign busy       = (state_q != ST_IDLE);
    assign load_done  = (state_q == ST_COMMIT) && !clear;
    assign err        = err_q;
    assign key_valid  = valid_q;
    assign dbg_state  = state_q;

    // accept mirrors the handshake for anyone probing the design.
    logic unused_accept;
    assign unused_accept = accept;

endmodule : key_bank

// File: doc/key_bank.md
Name: key_bank

Overview:
Parametrised key store for the I2C Triple-DES datapath. It replaces the single-key enable-hold register with a bank of NUM_KEYS registers, each KEY_W bits wide. Keys are loaded byte-serially from the I2C slave byte stream using a valid/ready handshake. Each key is committed atomically, carries a per-key valid flag, and is read through a select port by the DES round controller.

Parameters:
NUM_KEYS, 3, number of key slots (K1/K2/K3 for 3DES); must be >= 2
KEY_W, 64, key width in bits; must be a multiple of 8
IDX_W, $clog2(NUM_KEYS), width of slot index ports (derived, not overridden)

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous active-low reset
load_start  in  1  request to begin loading slot load_idx (sampled in IDLE only)
load_idx  in  IDX_W  target slot for load_start
byte_in  in  8  key byte, MSB-first
byte_valid  in  1  byte_in is valid this cycle
byte_ready  out  1  bank accepts a byte this cycle
clear  in  1  synchronous wipe of all slots
rd_sel  in  IDX_W  slot selected for key_out
key_out  out  KEY_W  contents of slot rd_sel (combinational mux of registers)
key_valid  out  NUM_KEYS  bit i = slot i holds a fully committed key
busy  out  1  high in LOAD and COMMIT
load_done  out  1  one-cycle pulse when a slot commits
err  out  1  one-cycle pulse on a rejected request

Behaviour:
- Reset (n_rst=0, async): all slots 0; key_valid=0; staging=0; byte counter=0; state=IDLE; byte_ready, busy, load_done, err all 0.
- FSM states: IDLE, LOAD, COMMIT.
- IDLE, load_start=1, load_idx<NUM_KEYS:
  - latch load_idx; clear key_valid[load_idx] on the same edge; counter=0; go to LOAD.
- IDLE, load_start=1, load_idx>=NUM_KEYS: err pulse next cycle; stay IDLE; no state changes.
- LOAD:
  - byte_ready=1.
  - Handshake fires when byte_valid && byte_ready: staging <= {staging[KEY_W-9:0], byte_in}; counter+1.
  - When the accepted byte is number KEY_W/8 (counter == KEY_W/8-1): go to COMMIT. Gaps in byte_valid are allowed, with no timeout.
  - load_start=1 while in LOAD: ignored; err pulse.
- COMMIT (exactly 1 cycle):
  - byte_ready=0; slot[idx] <= staging; key_valid[idx] <= 1; load_done=1 during this cycle; next state IDLE.
  - The new key is visible on key_out (when rd_sel=idx) from the cycle after COMMIT.
- A slot never exposes a partially loaded key: bank registers are written only in COMMIT.
- clear=1 has the highest priority, in any state:
  - all slots 0, key_valid=0, staging=0, counter=0, state IDLE next cycle.
  - Any in-flight load is aborted; no load_done.
  - A byte offered in the same cycle is not accepted (byte_ready forced 0 while clear=1).
- rd_sel>=NUM_KEYS: key_out = 0.
- Reloading a valid slot: its valid bit drops at load start. Its old contents remain on key_out until COMMIT overwrites them.
- Counter width: $clog2(KEY_W/8)+1. No wrap-around is possible because LOAD exits at the terminal count.
- Reset asserted mid-load: everything returns to reset values immediately; no load_done or err.

Decomposition:
- Package key_bank_pkg:
  - state enum type (IDLE, LOAD, COMMIT);
  - function bytes_per_key(KEY_W);
  - localparam BYTE_W=8.
- Sub-module key_slot:
  - one KEY_W register with write-enable and synchronous clear, async n_rst;
  - instantiated NUM_KEYS times by generate.
- FSM, staging shift register, counter and read mux live in key_bank.

Test Plan:
- Load slot 0 with bytes 0x01..0x08 on consecutive cycles, rd_sel=0 -> load_done pulses the cycle after byte 0x08 is accepted; key_out=64'h0102030405060708; key_valid=3'b001; busy low afterwards.
- Load slot 2 with bytes 0xA0..0xA7, byte_valid idle for 3 cycles between each byte -> key_out(rd_sel=2)=64'hA0A1A2A3A4A5A6A7; key_valid[2] stays 0 until COMMIT; slot 0 unchanged.
- Start a load of slot 1, send 4 bytes, assert clear for 1 cycle -> key_valid=0; all key_out=0; state IDLE; no load_done; the next full load of slot 1 with 0x11..0x18 commits correctly.
- load_start with load_idx=3 (NUM_KEYS=3) -> err pulses once; busy stays 0; key_valid unchanged. load_start during LOAD -> err pulse; the current load completes unaffected.
- Reload valid slot 0 with 0xFF..0xF8 -> key_valid[0]=0 from the cycle after load_start until COMMIT; key_out shows the old key until COMMIT, then 64'hFFFEFDFCFBFAF9F8.
- Assert n_rst low asynchronously mid-load (between clock edges) -> outputs reach reset values immediately; after release, a full load of slot 1 succeeds.
